// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline sequencer for the 5-stage RV32 core. Drives the enable
//            and bubble controls of the IF/ID, ID/EX and EX/MEM latches.
//            It handles load-use stalls, taken-branch flushes and
//            data-memory wait states. It also keeps saturating counters for
//            stall cycles and flush events.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int LU_CYCLES    = 1,   // bubbles per load-use hazard (1..7)
  parameter int FLUSH_CYCLES = 2    // IF/ID flush cycles after a taken branch (1..7)
) (
  input  logic        stg_clk,
  input  logic        reset,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic        i_id_rs1_used,
  input  logic        i_id_rs2_used,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_save_to_reg,
  input  logic        i_ex_rd_memory,
  input  logic        i_branch_taken,
  input  logic        i_mem_req,
  input  logic        i_mem_ready,
  output logic        o_if_ena,
  output logic        o_id_flush,
  output logic        o_ex_ena,
  output logic        o_ex_bubble,
  output logic        o_mem_ena,
  output logic [1:0]  o_state_out,
  output logic [15:0] o_stall_cycles,
  output logic [7:0]  o_flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU       = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  // Down-counter reload values: the entry cycle itself is the first bubble.
  localparam logic [2:0] C_LU_RELOAD    = 3'(LU_CYCLES - 1);
  localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
  localparam state_t     C_LU_NEXT      = (LU_CYCLES > 1)    ? ST_LU    : ST_RUN;
  localparam state_t     C_FLUSH_NEXT   = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  state_t      r_state;
  state_t      r_ret_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_stall_cycles;
  logic [7:0]  r_flush_events;

  logic        w_hz;
  logic        w_ms;
  logic        w_rs1_hit;
  logic        w_rs2_hit;
  state_t      w_eff_state;
  state_t      w_state_nxt;
  state_t      w_ret_nxt;
  logic [2:0]  w_cnt_nxt;
  logic        w_flush_accept;
  logic        w_if_ena;
  logic        w_id_flush;
  logic        w_ex_ena;
  logic        w_ex_bubble;
  logic        w_mem_ena;

  // Hazard and memory-wait detection from the current stage contents.
  assign w_rs1_hit = i_id_rs1_used & (i_id_rs1 == i_ex_rd);
  assign w_rs2_hit = i_id_rs2_used & (i_id_rs2 == i_ex_rd);
  assign w_hz      = i_id_valid & i_ex_rd_memory & i_ex_save_to_reg &
                     (i_ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
  assign w_ms      = i_mem_req & ~i_mem_ready;

  // Leaving MEM_WAIT resumes the saved state's rules in the same cycle.
  assign w_eff_state = (r_state == ST_MEM_WAIT) ? r_ret_state : r_state;

  // Mealy output decode and next-state selection, highest priority first.
  always_comb begin
    w_if_ena       = 1'b1;
    w_id_flush     = 1'b0;
    w_ex_ena       = 1'b1;
    w_ex_bubble    = 1'b0;
    w_mem_ena      = 1'b1;
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret_state;
    w_cnt_nxt      = r_cnt;
    w_flush_accept = 1'b0;
    if (reset) begin
      w_if_ena    = 1'b0;
      w_ex_ena    = 1'b0;
      w_mem_ena   = 1'b0;
      w_state_nxt = ST_RUN;
      w_ret_nxt   = ST_RUN;
      w_cnt_nxt   = 3'd0;
    end else if (w_ms) begin
      // Whole pipe freezes; a held branch is not counted until accepted.
      w_if_ena  = 1'b0;
      w_ex_ena  = 1'b0;
      w_mem_ena = 1'b0;
      if (r_state != ST_MEM_WAIT) begin
        w_ret_nxt   = r_state;
        w_state_nxt = ST_MEM_WAIT;
      end
    end else if (i_branch_taken) begin
      // A taken branch overrides a load-use hazard and restarts any flush.
      w_id_flush     = 1'b1;
      w_ex_bubble    = 1'b1;
      w_state_nxt    = C_FLUSH_NEXT;
      w_cnt_nxt      = C_FLUSH_RELOAD;
      w_flush_accept = 1'b1;
    end else if (w_eff_state == ST_LU) begin
      w_if_ena    = 1'b0;
      w_ex_bubble = 1'b1;
      w_cnt_nxt   = r_cnt - 3'd1;
      w_state_nxt = (r_cnt == 3'd1) ? ST_RUN : ST_LU;
    end else if (w_eff_state == ST_FLUSH) begin
      w_id_flush  = 1'b1;
      w_ex_bubble = 1'b1;
      w_cnt_nxt   = r_cnt - 3'd1;
      w_state_nxt = (r_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
    end else if (w_hz) begin
      w_if_ena    = 1'b0;
      w_ex_bubble = 1'b1;
      w_state_nxt = C_LU_NEXT;
      w_cnt_nxt   = C_LU_RELOAD;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  // Sequencer state, saved return state and bubble down-counter.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_cnt       <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret_state <= w_ret_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (!w_if_ena && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  // Saturating count of accepted taken branches.
  always_ff @(posedge stg_clk or posedge reset) begin
    if (reset) begin
      r_flush_events <= 8'd0;
    end else if (w_flush_accept && (r_flush_events != 8'hFF)) begin
      r_flush_events <= r_flush_events + 8'd1;
    end
  end

  assign o_if_ena       = w_if_ena;
  assign o_id_flush     = w_id_flush;
  assign o_ex_ena       = w_ex_ena;
  assign o_ex_bubble    = w_ex_bubble;
  assign o_mem_ena      = w_mem_ena;
  assign o_state_out    = r_state;
  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Scoreboard bench for pipe_hazard_ctrl. Two instances run side by
//            side: one with default parameters and one with LU_CYCLES=3.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        stg_clk;
  logic        reset;
  logic        r_id_valid, r_rs1_used, r_rs2_used, r_save, r_ldmem, r_br, r_mreq, r_mrdy;
  logic [4:0]  r_rs1, r_rs2, r_exrd;

  logic        w_if_ena   [2];
  logic        w_id_flush [2];
  logic        w_ex_ena   [2];
  logic        w_ex_bub   [2];
  logic        w_mem_ena  [2];
  logic [1:0]  w_state    [2];
  logic [15:0] w_stall    [2];
  logic [7:0]  w_flush    [2];

  typedef struct packed {
    logic        if_ena;
    logic        id_flush;
    logic        ex_ena;
    logic        ex_bub;
    logic        mem_ena;
    logic [1:0]  st;
    logic [15:0] stall;
    logic [7:0]  flush;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_chk;
  int n_pass;

  // Reference model state, index 0 = default DUT, 1 = LU_CYCLES=3 DUT.
  int m_state[2];
  int m_ret  [2];
  int m_cnt  [2];
  int m_stall[2];
  int m_flush[2];

  pipe_hazard_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(2)) u_dut0 (
    .stg_clk(stg_clk), .reset(reset), .i_id_valid(r_id_valid),
    .i_id_rs1(r_rs1), .i_id_rs2(r_rs2), .i_id_rs1_used(r_rs1_used),
    .i_id_rs2_used(r_rs2_used), .i_ex_rd(r_exrd), .i_ex_save_to_reg(r_save),
    .i_ex_rd_memory(r_ldmem), .i_branch_taken(r_br), .i_mem_req(r_mreq),
    .i_mem_ready(r_mrdy), .o_if_ena(w_if_ena[0]), .o_id_flush(w_id_flush[0]),
    .o_ex_ena(w_ex_ena[0]), .o_ex_bubble(w_ex_bub[0]), .o_mem_ena(w_mem_ena[0]),
    .o_state_out(w_state[0]), .o_stall_cycles(w_stall[0]), .o_flush_events(w_flush[0])
  );

  pipe_hazard_ctrl #(.LU_CYCLES(3), .FLUSH_CYCLES(2)) u_dut1 (
    .stg_clk(stg_clk), .reset(reset), .i_id_valid(r_id_valid),
    .i_id_rs1(r_rs1), .i_id_rs2(r_rs2), .i_id_rs1_used(r_rs1_used),
    .i_id_rs2_used(r_rs2_used), .i_ex_rd(r_exrd), .i_ex_save_to_reg(r_save),
    .i_ex_rd_memory(r_ldmem), .i_branch_taken(r_br), .i_mem_req(r_mreq),
    .i_mem_ready(r_mrdy), .o_if_ena(w_if_ena[1]), .o_id_flush(w_id_flush[1]),
    .o_ex_ena(w_ex_ena[1]), .o_ex_bubble(w_ex_bub[1]), .o_mem_ena(w_mem_ena[1]),
    .o_state_out(w_state[1]), .o_stall_cycles(w_stall[1]), .o_flush_events(w_flush[1])
  );

  initial stg_clk = 1'b0;
  always #5 stg_clk = ~stg_clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
  endtask

  // Load-use hazard as the architecture defines it.
  function automatic logic model_hz();
    return r_id_valid && r_ldmem && r_save && (r_exrd != 5'd0) &&
           ((r_rs1_used && r_rs1 == r_exrd) || (r_rs2_used && r_rs2 == r_exrd));
  endfunction

  // One cycle of the sequencer behaviour: expected outputs, then state update.
  task automatic model_step(input int k, input int lu, input int fc, output exp_t e);
    int eff;
    logic ms;
    ms  = r_mreq && !r_mrdy;
    e   = '0;
    if (reset) begin
      m_state[k] = 0; m_ret[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      return;
    end
    e.st    = 2'(m_state[k]);
    e.stall = 16'(m_stall[k]);
    e.flush = 8'(m_flush[k]);
    eff = (m_state[k] == 3) ? m_ret[k] : m_state[k];
    if (ms) begin
      if (m_state[k] != 3) begin
        m_ret[k]   = m_state[k];
        m_state[k] = 3;
      end
    end else if (r_br) begin
      {e.if_ena, e.id_flush, e.ex_ena, e.ex_bub, e.mem_ena} = 5'b11111;
      m_state[k] = (fc > 1) ? 2 : 0;
      m_cnt[k]   = fc - 1;
      if (m_flush[k] < 255) m_flush[k]++;
    end else if (eff == 1 || eff == 2) begin
      e.if_ena = (eff == 2); e.id_flush = (eff == 2);
      e.ex_ena = 1'b1; e.ex_bub = 1'b1; e.mem_ena = 1'b1;
      m_state[k] = (m_cnt[k] == 1) ? 0 : eff;
      m_cnt[k]--;
    end else if (model_hz()) begin
      {e.if_ena, e.id_flush, e.ex_ena, e.ex_bub, e.mem_ena} = 5'b00111;
      m_state[k] = (lu > 1) ? 1 : 0;
      m_cnt[k]   = lu - 1;
    end else begin
      {e.if_ena, e.id_flush, e.ex_ena, e.ex_bub, e.mem_ena} = 5'b10101;
      m_state[k] = 0;
    end
    if (!e.if_ena && m_stall[k] < 65535) m_stall[k]++;
  endtask

  // Drive the current inputs for one cycle and queue the expected response.
  task automatic step();
    exp_t e0, e1;
    model_step(0, 1, 2, e0);
    model_step(1, 3, 2, e1);
    q0.push_back(e0);
    q1.push_back(e1);
    @(posedge stg_clk);
    #1;
  endtask

  task automatic idle_inputs();
    r_id_valid = 0; r_rs1 = 0; r_rs2 = 0; r_rs1_used = 0; r_rs2_used = 0;
    r_exrd = 0; r_save = 0; r_ldmem = 0; r_br = 0; r_mreq = 0; r_mrdy = 1;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic rs1u);
    r_id_valid = 1; r_rs1 = 5; r_rs2 = 7; r_rs1_used = rs1u; r_rs2_used = 1;
    r_exrd = rd; r_save = 1; r_ldmem = 1;
  endtask

  task automatic cmp(input int k, input exp_t e);
    string s;
    s = (k == 0) ? "d0" : "d1";
    check_eq({s, "_if_ena"},   32'(w_if_ena[k]),   32'(e.if_ena));
    check_eq({s, "_id_flush"}, 32'(w_id_flush[k]), 32'(e.id_flush));
    check_eq({s, "_ex_ena"},   32'(w_ex_ena[k]),   32'(e.ex_ena));
    check_eq({s, "_ex_bub"},   32'(w_ex_bub[k]),   32'(e.ex_bub));
    check_eq({s, "_mem_ena"},  32'(w_mem_ena[k]),  32'(e.mem_ena));
    check_eq({s, "_state"},    32'(w_state[k]),    32'(e.st));
    check_eq({s, "_stall"},    32'(w_stall[k]),    32'(e.stall));
    check_eq({s, "_flush"},    32'(w_flush[k]),    32'(e.flush));
  endtask

  // Scoreboard consumer: settled outputs are compared mid-cycle.
  always @(negedge stg_clk) begin
    if (q0.size() > 0) cmp(0, q0.pop_front());
    if (q1.size() > 0) cmp(1, q1.pop_front());
  end

  initial begin
    int s0;
    n_chk = 0; n_pass = 0;
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_ret[k] = 0; m_cnt[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    idle_inputs();
    reset = 1;
    @(posedge stg_clk); #1;
    step(); step();
    check_eq("rst_if_ena", 32'(w_if_ena[0]), 32'd0);
    reset = 0;
    step(); step();

    // Load-use on x5: one bubble (d0), three bubbles (d1).
    load_use(5'd5, 1'b1); step();
    idle_inputs(); repeat (4) step();
    check_eq("lu_stall_d0", 32'(w_stall[0]), 32'd1);
    check_eq("lu_stall_d1", 32'(w_stall[1]), 32'd3);

    // x0 destination and unused rs1: no stall.
    load_use(5'd0, 1'b1); r_rs2 = 5'd0; step();
    load_use(5'd5, 1'b0); step();
    load_use(5'd7, 1'b0); step();   // rs2 match does stall
    idle_inputs(); repeat (4) step();

    // Single taken branch.
    s0 = int'(w_stall[0]);
    r_br = 1; step();
    r_br = 0; repeat (3) step();
    check_eq("br_flush_ev", 32'(w_flush[0]), 32'd1);

    // Memory wait during FLUSH with cnt=1.
    r_br = 1; step();
    r_br = 0; r_mreq = 1; r_mrdy = 0; repeat (4) step();
    r_mreq = 0; r_mrdy = 1; repeat (3) step();
    check_eq("mw_stall_inc", 32'(w_stall[0]), 32'(s0 + 4));

    // Branch and hazard together: flush only.
    load_use(5'd5, 1'b1); r_br = 1; step();
    idle_inputs(); repeat (3) step();

    // Branch held through a memory wait counts once.
    s0 = int'(w_flush[0]);
    r_br = 1; r_mreq = 1; r_mrdy = 0; repeat (3) step();
    r_mreq = 0; r_mrdy = 1; step();
    r_br = 0; repeat (2) step();
    check_eq("br_ms_once", 32'(w_flush[0]), 32'(s0 + 1));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r_id_valid = 1'($urandom_range(0, 3) != 0);
      r_rs1 = 5'($urandom_range(0, 7)); r_rs2 = 5'($urandom_range(0, 7));
      r_rs1_used = 1'($urandom); r_rs2_used = 1'($urandom);
      r_exrd = 5'($urandom_range(0, 7)); r_save = 1'($urandom); r_ldmem = 1'($urandom);
      r_br = 1'($urandom_range(0, 7) == 0);
      r_mreq = 1'($urandom_range(0, 3) == 0); r_mrdy = 1'($urandom);
      step();
    end
    idle_inputs(); repeat (3) step();

    // flush_events saturation.
    r_br = 1; repeat (300) step();
    r_br = 0; repeat (2) step();
    check_eq("flush_sat", 32'(w_flush[0]), 32'hFF);

    // stall_cycles saturation.
    r_mreq = 1; r_mrdy = 0; repeat (70000) step();
    r_mreq = 0; r_mrdy = 1; repeat (2) step();
    check_eq("stall_sat", 32'(w_stall[0]), 32'hFFFF);

    // Reset mid-LU on the LU_CYCLES=3 instance.
    load_use(5'd5, 1'b1); step();
    idle_inputs(); step();
    check_eq("mid_lu_state", 32'(w_state[1]), 32'd1);
    reset = 1; #1;
    check_eq("rst_async_ex_ena", 32'(w_ex_ena[1]), 32'd0);
    check_eq("rst_async_bub",    32'(w_ex_bub[1]), 32'd0);
    check_eq("rst_async_state",  32'(w_state[1]), 32'd0);
    step();
    reset = 0; step();
    check_eq("post_rst_stall", 32'(w_stall[1]), 32'd0);
    check_eq("post_rst_flush", 32'(w_flush[1]), 32'd0);
    check_eq("post_rst_if",    32'(w_if_ena[1]), 32'd1);
    repeat (2) step();
    check_eq("sb_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
